// File: rtl/decoder_arbiter_8_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
package decoder_arbiter_8_pkg;
  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;
  localparam int HOLD_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/decoder_arbiter_8_if.sv
// Request/grant bundle between requesters and the arbiter.
interface decoder_arbiter_8_if
  import decoder_arbiter_8_pkg::*;
();
  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               preempt;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_valid, preempt
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_valid, preempt
  );
endinterface

// File: rtl/decoder_arbiter_8_decoder_3x8.sv
// Gated 3-to-8 one-hot decoder for the grant vector.
module decoder_3x8
  import decoder_arbiter_8_pkg::*;
(
  input  logic [IDX_W-1:0]   i_idx,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_dec
);
  assign o_dec = i_en ? (NUM_REQ'(1) << i_idx) : '0;
endmodule

// File: rtl/decoder_arbiter_8.sv
// Round-robin arbiter over 8 requesters with hold limit and preempt pulse.
module decoder_arbiter_8
  import decoder_arbiter_8_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  decoder_arbiter_8_if.slave bus
);
  state_t            r_state, w_state_nx;
  logic [IDX_W-1:0]  r_idx, w_idx_nx;
  logic [IDX_W-1:0]  r_last, w_last_nx;
  logic [IDX_W-1:0]  w_win, w_cand;
  logic              w_found;
  logic              r_valid, w_valid_nx;
  logic              r_pre, w_pre_nx;
  logic [HOLD_W-1:0] r_hold, w_hold_nx;
  logic              w_hold_max;
  logic              w_cur_req;

  // Scan upward from the requester after the last grantee, wrapping.
  always_comb begin
    w_win   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = r_last + IDX_W'(i);
      if (!w_found && bus.req[w_cand]) begin
        w_win   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  assign w_hold_max = (r_hold == HOLD_W'(MAX_HOLD));
  assign w_cur_req  = bus.req[r_idx];

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_last_nx  = r_last;
    w_valid_nx = r_valid;
    w_hold_nx  = r_hold;
    w_pre_nx   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_state_nx = GRANT;
          w_idx_nx   = w_win;
          w_valid_nx = 1'b1;
          w_hold_nx  = HOLD_W'(1);
        end else begin
          w_idx_nx   = '0;
          w_valid_nx = 1'b0;
          w_hold_nx  = '0;
        end
      end
      GRANT: begin
        if (bus.done || !w_cur_req || w_hold_max) begin
          w_state_nx = IDLE;
          w_idx_nx   = '0;
          w_valid_nx = 1'b0;
          w_hold_nx  = '0;
          w_last_nx  = r_idx;
          // A normal release wins over the hold limit.
          w_pre_nx   = w_hold_max && !bus.done && w_cur_req;
        end else begin
          w_hold_nx  = r_hold + HOLD_W'(1);
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_last  <= IDX_W'(NUM_REQ - 1);
      r_valid <= 1'b0;
      r_hold  <= '0;
      r_pre   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_last  <= w_last_nx;
      r_valid <= w_valid_nx;
      r_hold  <= w_hold_nx;
      r_pre   <= w_pre_nx;
    end
  end

  assign bus.gnt_idx   = r_idx;
  assign bus.gnt_valid = r_valid;
  assign bus.preempt   = r_pre;

  decoder_3x8 u_dec (
    .i_idx (r_idx),
    .i_en  (r_valid),
    .o_dec (bus.gnt)
  );
endmodule

// File: tb/tb_decoder_arbiter_8.sv
// Directed bench for decoder_arbiter_8 with a cycle-level reference model.
module tb_decoder_arbiter_8;
  localparam int MAXH = 4;

  logic clk;
  logic rst_n;
  int   errs;
  int   checks;

  decoder_arbiter_8_if bus ();

  decoder_arbiter_8 #(.MAX_HOLD(MAXH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who holds the resource, for how long, who went last.
  bit m_active;
  int m_idx;
  int m_hold;
  int m_last;
  bit m_pre;

  function automatic int pick(logic [7:0] r, int last);
    for (int k = 1; k <= 8; k++) begin
      if (r[(last + k) % 8]) return (last + k) % 8;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_idx    <= 0;
      m_hold   <= 0;
      m_last   <= 7;
      m_pre    <= 1'b0;
    end else if (!m_active) begin
      m_pre <= 1'b0;
      if (bus.req != 8'h00) begin
        m_active <= 1'b1;
        m_idx    <= pick(bus.req, m_last);
        m_hold   <= 1;
      end
    end else begin
      if (bus.done || !bus.req[m_idx] || m_hold == MAXH) begin
        m_active <= 1'b0;
        m_last   <= m_idx;
        m_pre    <= !bus.done && bus.req[m_idx] && m_hold == MAXH;
        m_idx    <= 0;
      end else begin
        m_hold <= m_hold + 1;
      end
    end
  end

  task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      logic [7:0] eg;
      eg = m_active ? (8'h01 << m_idx) : 8'h00;
      chk("model_gnt", bus.gnt, eg);
      chk("model_idx", 8'(bus.gnt_idx), m_active ? 8'(m_idx) : 8'h00);
      chk("model_valid", 8'(bus.gnt_valid), 8'(m_active));
      chk("model_preempt", 8'(bus.preempt), 8'(m_pre));
      chk("onehot", 8'($countones(bus.gnt) <= 1), 8'h01);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [7:0] vreq [24] = '{
    8'h12, 8'h12, 8'h13, 8'h02, 8'h00, 8'h40, 8'h41, 8'h41,
    8'h41, 8'h41, 8'h41, 8'h01, 8'h81, 8'h81, 8'h80, 8'hA5,
    8'hA5, 8'hA5, 8'h24, 8'h24, 8'h00, 8'h00, 8'h08, 8'h08
  };
  logic vdone [24] = '{
    0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
    0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1
  };

  initial begin
    errs     = 0;
    checks   = 0;
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    #2;
    chk("rst_gnt", bus.gnt, 8'h00);
    chk("rst_idx", 8'(bus.gnt_idx), 8'h00);
    chk("rst_valid", 8'(bus.gnt_valid), 8'h00);
    chk("rst_preempt", 8'(bus.preempt), 8'h00);
    step();
    rst_n = 1'b1;

    // Single requester 0, one cycle latency.
    bus.req = 8'h01;
    step();
    chk("r30_gnt", bus.gnt, 8'h01);
    chk("r30_idx", 8'(bus.gnt_idx), 8'h00);
    chk("r30_valid", 8'(bus.gnt_valid), 8'h01);
    bus.req = 8'h00;
    step();

    // Full request, done on each grant's second cycle.
    do_reset();
    bus.req = 8'hFF;
    step();
    for (int k = 0; k < 9; k++) begin
      chk("r31_idx", 8'(bus.gnt_idx), 8'(k % 8));
      chk("r31_gnt", bus.gnt, 8'h01 << (k % 8));
      step();
      chk("r31_hold", 8'(bus.gnt_idx), 8'(k % 8));
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      chk("r31_bubble", bus.gnt, 8'h00);
      chk("r31_nopre", 8'(bus.preempt), 8'h00);
      step();
    end
    bus.req = 8'h00;
    step();
    step();

    // Hold limit forces a preempt, then re-grant to the same requester.
    do_reset();
    bus.req = 8'h04;
    step();
    for (int c = 0; c < MAXH; c++) begin
      chk("r32_held", bus.gnt, 8'h04);
      step();
    end
    chk("r32_bubble", bus.gnt, 8'h00);
    chk("r32_pre", 8'(bus.preempt), 8'h01);
    step();
    chk("r32_regnt", bus.gnt, 8'h04);
    chk("r32_pre_off", 8'(bus.preempt), 8'h00);
    bus.req = 8'h00;
    step();
    step();

    // Grantee drops its request; next winner is 7.
    do_reset();
    bus.req = 8'h08;
    step();
    chk("r33_g3", 8'(bus.gnt_idx), 8'h03);
    bus.req = 8'h88;
    step();
    chk("r33_still3", bus.gnt, 8'h08);
    bus.req = 8'h80;
    step();
    chk("r33_idle", 8'(bus.gnt_valid), 8'h00);
    chk("r33_nopre", 8'(bus.preempt), 8'h00);
    step();
    chk("r33_g7", bus.gnt, 8'h80);
    bus.req = 8'h00;
    step();
    step();

    // done on the hold-limit cycle is a normal release.
    do_reset();
    bus.req = 8'h04;
    repeat (MAXH) step();
    chk("r34_lastheld", bus.gnt, 8'h04);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    chk("r34_idle", bus.gnt, 8'h00);
    chk("r34_nopre", 8'(bus.preempt), 8'h00);
    step();
    chk("r34_regnt", bus.gnt, 8'h04);
    bus.req = 8'h00;
    step();
    step();

    // Asynchronous reset in the middle of a grant.
    do_reset();
    bus.req = 8'h20;
    step();
    chk("r35_g5", 8'(bus.gnt_idx), 8'h05);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r35_async_gnt", bus.gnt, 8'h00);
    chk("r35_async_valid", 8'(bus.gnt_valid), 8'h00);
    chk("r35_async_idx", 8'(bus.gnt_idx), 8'h00);
    bus.req = 8'hFF;
    step();
    rst_n = 1'b1;
    step();
    chk("r35_first0", bus.gnt, 8'h01);
    bus.req = 8'h00;
    step();
    step();

    // Mixed vector table, checked only by the model.
    do_reset();
    for (int v = 0; v < 24; v++) begin
      bus.req  = vreq[v];
      bus.done = vdone[v];
      step();
    end
    bus.req  = 8'h00;
    bus.done = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/decoder_arbiter_8.md
DECODER_ARBITER_8 -- requirements
Module: decoder_arbiter_8

Interface
REQ-001 Parameter: MAX_HOLD, 4, max consecutive cycles one requester may hold a grant (legal range 1..15).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  8  request vector; bit i = requester i.
REQ-006 done  input  1  current grantee releases the resource; ignored unless gnt_valid=1.
REQ-007 gnt  output  8  one-hot grant, all zero when no grant.
REQ-008 gnt_idx  output  3  binary index of current grantee; 0 when gnt_valid=0.
REQ-009 gnt_valid  output  1  high while a grant is active.
REQ-010 preempt  output  1  one-cycle pulse when a grant is forcibly ended by MAX_HOLD.

Function
REQ-011 The FSM SHALL have exactly two states, IDLE and GRANT.
REQ-012 IDLE: if req != 0, SHALL select the winner and enter GRANT on the next edge; otherwise SHALL stay in IDLE.
REQ-013 Winner SHALL be the first set req bit scanning upward from (last_idx+1) mod 8, wrapping 7->0; last_idx SHALL be the previous grantee.
REQ-014 Latency: gnt, gnt_idx and gnt_valid SHALL be registered and assert the cycle after req is sampled in IDLE (1-cycle latency).
REQ-015 gnt SHALL equal the 3-to-8 decode of gnt_idx when gnt_valid=1 and 8'h00 otherwise; no more than one gnt bit SHALL ever be set.
REQ-016 GRANT: hold_cnt SHALL start at 1 on the first grant cycle and increment each cycle the grant is held.
REQ-017 GRANT exits to IDLE on the next edge when any of: done=1; req[gnt_idx]=0; hold_cnt==MAX_HOLD.
REQ-018 If hold_cnt==MAX_HOLD and done=0 and req[gnt_idx]=1, preempt SHALL pulse high for the first IDLE cycle only.
REQ-019 If done=1 coincides with hold_cnt==MAX_HOLD, the release SHALL be treated as normal: preempt stays 0.
REQ-020 On every GRANT->IDLE transition last_idx SHALL be updated to gnt_idx.
REQ-021 Exactly one IDLE cycle with gnt=0 SHALL separate consecutive grants (bubble), including a re-grant to the same requester.
REQ-022 Changes to req bits other than req[gnt_idx] during GRANT SHALL have no effect until the next IDLE cycle.
REQ-023 With a single active requester, that requester SHALL be re-granted after each bubble.

Reset
REQ-024 On rst_n=0: state=IDLE, gnt=8'h00, gnt_idx=0, gnt_valid=0, preempt=0, hold_cnt=0, last_idx=7, so that requester 0 has first priority after reset.
REQ-025 Reset asserted mid-grant SHALL clear all outputs immediately, without waiting for a clock edge.
REQ-026 The first arbitration SHALL occur on the first rising edge after rst_n deasserts.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE, GRANT), NUM_REQ=8 and IDX_W=3.
REQ-028 The one-hot gnt SHALL be produced by one instance of sub-module decoder_3x8 fed from gnt_idx and gated by gnt_valid.
REQ-029 The round-robin priority scan SHALL be combinational logic inside decoder_arbiter_8; all outputs SHALL be registered.

Verification
REQ-030 Reset then req=8'h01 -> one cycle later gnt=8'h01, gnt_idx=0, gnt_valid=1.
REQ-031 req=8'hFF held, done pulsed on each grant's 2nd cycle -> grant order 0,1,2,...,7,0, one bubble between each.
REQ-032 req=8'h04 held, done=0, MAX_HOLD=4 -> gnt=8'h04 for 4 cycles, then gnt=0 with preempt=1 for 1 cycle, then re-grant to 2.
REQ-033 Grant to 3 active; req=8'h88, then drop req[3] -> next cycle IDLE with preempt=0; following grant goes to 7.
REQ-034 done=1 on the same cycle hold_cnt==MAX_HOLD -> release with preempt=0.
REQ-035 rst_n pulsed low during GRANT on idx 5 -> gnt=0 asynchronously; with req=8'hFF after release, first grant goes to 0.
